isq_cond_update_bcast: RTL

Initiator side of the issue-queue condition-update broadcast. Collects condition-update requests (robid, mask, value) from up to `NUM_SRC` writeback/execution sources, buffers them in order in a small multi-write FIFO, and drives exactly one `update_condition_*` broadcast per cycle into the issue queue. Sits between the writeback ports and the ISQ, and squashes pending updates for entries killed by a rollback flush.

---
 rtl/isq_cond_update_bcast_pkg.sv | 52 +++++
 rtl/isq_cond_update_bcast_fifo.sv | 104 ++++++++++
 rtl/isq_cond_update_bcast.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/isq_cond_update_bcast_pkg.sv
// -----------------------------------------------------------------------------
// isq_cond_update_bcast_pkg
//
// Shared types and helpers for the issue-queue condition-update broadcast
// initiator:
//   - cbcast_entry_t : one buffered update {robid, mask, value, kill}
//   - is_younger()   : wrap-aware "entry is younger than flush boundary" test
//   - cbcast_ptr_w() : FIFO pointer width (index bits plus one wrap bit)
//
// Reuses the global ROB_SIZE_LOG, ISQ_CONDITION_WIDTH and ROB_STATE_ROLLIBACK
// macros. Fallback values are provided for standalone builds only.
// -----------------------------------------------------------------------------
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 6
`endif
`ifndef ISQ_CONDITION_WIDTH
`define ISQ_CONDITION_WIDTH 4
`endif
`ifndef ROB_STATE_ROLLIBACK
`define ROB_STATE_ROLLIBACK 2'd2
`endif

package isq_cond_update_bcast_pkg;

  // robid carries a wrap bit above the ROB index.
  localparam int ROBID_W = `ROB_SIZE_LOG + 1;
  localparam int COND_W  = `ISQ_CONDITION_WIDTH;

  localparam int CBCAST_DEFAULT_DEPTH = 8;

  typedef logic [ROBID_W-1:0] robid_t;
  typedef logic [COND_W-1:0]  cond_t;

  typedef struct packed {
    robid_t robid;
    cond_t  mask;
    cond_t  value;
    logic   kill;
  } cbcast_entry_t;

  // Pointer width: index bits plus one extra bit so full and empty differ.
  function automatic int cbcast_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // e is younger than f when it sits after f in ROB order. Differing wrap
  // bits invert the plain index comparison.
  function automatic logic is_younger(input robid_t e, input robid_t f);
    return f[ROBID_W-1] ^ e[ROBID_W-1] ^ (f[ROBID_W-2:0] < e[ROBID_W-2:0]);
  endfunction

endpackage

// File: rtl/isq_cond_update_bcast_fifo.sv
// -----------------------------------------------------------------------------
// cbcast_multi_push_fifo
//
// N-write / 1-read FIFO of cbcast_entry_t with a per-slot kill input.
//
// Ports:
//   clock, reset     : clock, asynchronous active-high reset
//   push_valid[N]    : write request per lane; lanes pack in ascending order
//   push_data[N]     : entry per lane (kill bit included)
//   pop              : remove the head entry (caller guarantees non-empty)
//   clear            : drop all contents (head <- tail), pushes ignored
//   kill_vec[D]      : set the kill bit of each flagged slot
//   head_entry       : current head entry, read before this cycle's pushes
//   slot_robid[D]    : robid stored in every slot, for flush comparison
//   empty, count     : occupancy (count = tail - head)
// -----------------------------------------------------------------------------
module cbcast_multi_push_fifo
  import isq_cond_update_bcast_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int FIFO_DEPTH = CBCAST_DEFAULT_DEPTH,
  localparam int PTR_W      = cbcast_ptr_w(FIFO_DEPTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic          [NUM_SRC-1:0]      push_valid,
  input  cbcast_entry_t [NUM_SRC-1:0]      push_data,
  input  logic                             pop,
  input  logic                             clear,
  input  logic          [FIFO_DEPTH-1:0]   kill_vec,
  output cbcast_entry_t                    head_entry,
  output robid_t        [FIFO_DEPTH-1:0]   slot_robid,
  output logic                             empty,
  output logic          [PTR_W-1:0]        count
);

  localparam int AW = PTR_W - 1;

  cbcast_entry_t                     mem [FIFO_DEPTH];
  logic          [FIFO_DEPTH-1:0]    kill_q;
  logic          [PTR_W-1:0]         head_q;
  logic          [PTR_W-1:0]         tail_q;
  logic          [NUM_SRC-1:0][PTR_W-1:0] wr_ptr;
  logic          [PTR_W-1:0]         push_cnt;

  // Each accepted lane lands at tail plus the number of accepted lanes
  // below it, so lanes pack densely in ascending index order.
  // NOTE: blocking '=' is correct here; push_cnt is a running sum inside one
  // combinational evaluation, and giving it a value before the loop also
  // keeps the block free of inferred latches.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      wr_ptr[i] = tail_q + push_cnt;
      if (push_valid[i]) push_cnt = push_cnt + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (clear) begin
      head_q <= tail_q;
    end else begin
      if (pop) head_q <= head_q + PTR_W'(1);
      tail_q <= tail_q + push_cnt;
    end
  end

  // Kill bits are sticky until the slot is rewritten by a push; a push
  // replaces whatever a flush marked in that (free) slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kill_q <= '0;
    end else begin
      kill_q <= kill_q | kill_vec;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_valid[i] && !clear) kill_q[wr_ptr[i][AW-1:0]] <= push_data[i].kill;
      end
    end
  end

  // NOTE: the payload array has no reset; only slots between head and tail
  // are ever observed, and pointers plus kill bits carry all reset state.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_valid[i] && !clear) mem[wr_ptr[i][AW-1:0]] <= push_data[i];
    end
  end

  always_comb begin
    head_entry      = mem[head_q[AW-1:0]];
    head_entry.kill = kill_q[head_q[AW-1:0]];
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) slot_robid[i] = mem[i].robid;
  end

  assign empty = (head_q == tail_q);
  assign count = tail_q - head_q;

endmodule

// File: rtl/isq_cond_update_bcast.sv
// -----------------------------------------------------------------------------
// isq_cond_update_bcast
//
// Initiator side of the issue-queue condition-update broadcast. Accepts up to
// NUM_SRC requests per cycle into an in-order FIFO and drives one registered
// update_condition_* broadcast per cycle. A rollback flush squashes pending
// updates for robids younger than flush_robid.
//
// Configuration macro ISQ_CBCAST_FLUSH_FILTER_EN:
//   defined   : selective kill of younger entries (FIFO, incoming, output)
//   undefined : a rollback flush empties the FIFO, drops same-cycle requests
//               and clears the output register
//   src_ready never depends on flush or src_valid.
//
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   src_valid/ready[N]       : per-source request handshake
//   src_robid/mask/value[N]  : request payload
//   update_condition_*       : registered broadcast to the issue queue
//   rob_state                : flush acts only in ROB_STATE_ROLLIBACK
//   flush_valid, flush_robid : flush request and boundary
//   pending_count            : occupied FIFO slots
// -----------------------------------------------------------------------------
module isq_cond_update_bcast
  import isq_cond_update_bcast_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int FIFO_DEPTH = CBCAST_DEFAULT_DEPTH,
  localparam int PTR_W      = cbcast_ptr_w(FIFO_DEPTH)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC-1:0][ROBID_W-1:0]   src_robid,
  input  logic [NUM_SRC-1:0][COND_W-1:0]    src_mask,
  input  logic [NUM_SRC-1:0][COND_W-1:0]    src_value,
  output logic                              update_condition_valid,
  output logic [ROBID_W-1:0]                update_condition_robid,
  output logic [COND_W-1:0]                 update_condition_mask,
  output logic [COND_W-1:0]                 update_condition_in,
  input  logic [1:0]                        rob_state,
  input  logic                              flush_valid,
  input  logic [ROBID_W-1:0]                flush_robid,
  output logic [PTR_W-1:0]                  pending_count
);

`ifdef ISQ_CBCAST_FLUSH_FILTER_EN
  localparam bit FLUSH_ALL = 1'b0;
`else
  localparam bit FLUSH_ALL = 1'b1;
`endif

  logic                             flush_act;
  logic                             clear_all;
  logic                             has_space;
  logic [NUM_SRC-1:0]               accept;
  logic [NUM_SRC-1:0]               push_valid;
  cbcast_entry_t [NUM_SRC-1:0]      push_data;
  logic [FIFO_DEPTH-1:0]            kill_vec;
  robid_t [FIFO_DEPTH-1:0]          slot_robid;
  cbcast_entry_t                    head_entry;
  logic                             fifo_empty;
  logic                             pop;
  logic                             head_young;
  logic [PTR_W-1:0]                 count;

  assign flush_act = flush_valid && (rob_state == `ROB_STATE_ROLLIBACK);
  assign clear_all = FLUSH_ALL && flush_act;

  // Ready is a function of registered occupancy only: worst case every
  // source pushes while nothing pops, so NUM_SRC free slots are required.
  assign has_space = (PTR_W'(FIFO_DEPTH) - count) >= PTR_W'(NUM_SRC);
  assign src_ready = {NUM_SRC{has_space}};
  assign accept    = src_valid & src_ready;

  // The younger-compare runs in both builds. When the whole FIFO is being
  // cleared the kill marks land only on dead slots and dropped pushes, so
  // they are harmless there.
  always_comb begin
    push_valid = clear_all ? '0 : accept;
    for (int i = 0; i < NUM_SRC; i++) begin
      push_data[i].robid = src_robid[i];
      push_data[i].mask  = src_mask[i];
      push_data[i].value = src_value[i];
      push_data[i].kill  = flush_act && is_younger(src_robid[i], flush_robid);
    end
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      kill_vec[i] = flush_act && is_younger(slot_robid[i], flush_robid);
    end
  end

  cbcast_multi_push_fifo #(
    .NUM_SRC    (NUM_SRC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop        (pop),
    .clear      (clear_all),
    .kill_vec   (kill_vec),
    .head_entry (head_entry),
    .slot_robid (slot_robid),
    .empty      (fifo_empty),
    .count      (count)
  );

  // The head is removed every non-empty cycle; an entry leaving during a
  // flush is checked here because kill_vec only reaches it next cycle.
  assign pop        = !fifo_empty;
  assign head_young = flush_act && is_younger(head_entry.robid, flush_robid);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      update_condition_valid <= 1'b0;
      update_condition_robid <= '0;
      update_condition_mask  <= '0;
      update_condition_in    <= '0;
    end else if (clear_all) begin
      update_condition_valid <= 1'b0;
      update_condition_robid <= '0;
      update_condition_mask  <= '0;
      update_condition_in    <= '0;
    end else if (pop) begin
      update_condition_valid <= !head_entry.kill && !head_young;
      update_condition_robid <= head_entry.robid;
      update_condition_mask  <= head_entry.mask;
      update_condition_in    <= head_entry.value;
    end else begin
      update_condition_valid <= 1'b0;
    end
  end

  assign pending_count = count;

endmodule
